// File: rtl/flattened_priority_pkg.sv
// Shared constants and bit-index helpers for the flattened priority framework.
// Opinion words are voter-major, then level, then input; results are level-major.
package flattened_priority_pkg;

   localparam int N_DEF = 24;
   localparam int P_DEF = 8;

   function automatic int opin_idx(int n, int j, int i,
                                   int nn = N_DEF, int pp = P_DEF);
      return n * pp * nn + j * nn + i;
   endfunction

   function automatic int res_idx(int j, int i, int nn = N_DEF);
      return j * nn + i;
   endfunction

endpackage

// File: rtl/priority_mask_reduce.sv
// Combinational slice: MASK=0 reduces voter opinions to agreement bits,
// MASK=1 keeps only the highest agreeing level per input.
module priority_mask_reduce
   import flattened_priority_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int P    = P_DEF,
   parameter bit MASK = 1'b0
) (
   input  logic [N*N*P-1:0] p_o,
   input  logic [N-1:0]     vote_en,
   input  logic [N*P-1:0]   agree,
   output logic [N*P-1:0]   res
);

   logic [N*P-1:0] red;
   logic [N*P-1:0] msk;
   logic [N-1:0]   seen;

   // an empty electorate never agrees
   always_comb begin
      red = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < P; j++) begin
            red[res_idx(j, i, N)] = |vote_en;
            for (int n = 0; n < N; n++) begin
               red[res_idx(j, i, N)] = red[res_idx(j, i, N)] &
                  (p_o[opin_idx(n, j, i, N, P)] | ~vote_en[n]);
            end
         end
      end
   end

   always_comb begin
      msk  = '0;
      seen = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = P - 1; j >= 0; j--) begin
            msk[res_idx(j, i, N)] = agree[res_idx(j, i, N)] & ~seen[i];
            seen[i] = seen[i] | agree[res_idx(j, i, N)];
         end
      end
   end

   assign res = MASK ? msk : red;

endmodule

// File: rtl/priority_mask_pipe.sv
// Two-stage agreement/mask pipeline with valid/ready handshake and flush.
// Optional PRIORITY_MASK_LVL_EN adds encoded level (o_lvl) and hit (o_hit).
module priority_mask_pipe
   import flattened_priority_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int P = P_DEF
`ifdef PRIORITY_MASK_LVL_EN
   ,
   parameter int LVL_W = (P > 1) ? $clog2(P) : 1
`endif
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_vld,
   output logic             o_rdy,
   input  logic [N*N*P-1:0] i_p_o,
   input  logic [N-1:0]     i_vote_en,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic [N*P-1:0]   o_p_r
`ifdef PRIORITY_MASK_LVL_EN
   ,
   output logic [N*LVL_W-1:0] o_lvl,
   output logic [N-1:0]       o_hit
`endif
);

   logic           s1_vld;
   logic [N*P-1:0] s1_agree;
   logic [N*P-1:0] agree_c;
   logic [N*P-1:0] mask_c;
   logic           s1_ld;
   logic           s2_ld;
   logic           in_xfer;
   logic           s2_take;

   assign s2_ld   = ~o_vld | i_rdy;
   assign s1_ld   = ~s1_vld | s2_ld;
   assign o_rdy   = s1_ld;
   assign in_xfer = i_vld & o_rdy;
   assign s2_take = s2_ld & s1_vld;

   priority_mask_reduce #(.N(N), .P(P), .MASK(1'b0)) u_reduce (
      .p_o     (i_p_o),
      .vote_en (i_vote_en),
      .agree   ('0),
      .res     (agree_c)
   );

   priority_mask_reduce #(.N(N), .P(P), .MASK(1'b1)) u_mask (
      .p_o     ('0),
      .vote_en ('0),
      .agree   (s1_agree),
      .res     (mask_c)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_vld   <= 1'b0;
         s1_agree <= '0;
      end else begin
         if (i_flush)
            s1_vld <= 1'b0;
         else if (s1_ld)
            s1_vld <= i_vld;
         if (in_xfer)
            s1_agree <= agree_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_vld <= 1'b0;
         o_p_r <= '0;
      end else begin
         if (i_flush)
            o_vld <= 1'b0;
         else if (s2_ld)
            o_vld <= s1_vld;
         if (s2_take)
            o_p_r <= mask_c;
      end
   end

`ifdef PRIORITY_MASK_LVL_EN
   logic [N*LVL_W-1:0] lvl_c;
   logic [N-1:0]       hit_c;

   always_comb begin
      lvl_c = '0;
      hit_c = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < P; j++) begin
            if (mask_c[res_idx(j, i, N)]) begin
               lvl_c[i*LVL_W +: LVL_W] = LVL_W'(j);
               hit_c[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_lvl <= '0;
         o_hit <= '0;
      end else if (s2_take) begin
         o_lvl <= lvl_c;
         o_hit <= hit_c;
      end
   end
`endif

endmodule

// File: tb/tb_priority_mask_pipe.sv
// Randomized and directed bench for priority_mask_pipe with a
// counting-based reference model and an in-flight word queue.
module tb_priority_mask_pipe;

`ifdef PRIORITY_MASK_LVL_EN
   localparam int N = 24;
   localparam int P = 8;
   localparam int LVL_W = 3;
`else
   localparam int N = 4;
   localparam int P = 3;
`endif
   localparam int OW = N * N * P;
   localparam int RW = N * P;

   logic          clk;
   logic          rst_n;
   logic          i_flush;
   logic          i_vld;
   logic          o_rdy;
   logic [OW-1:0] i_p_o;
   logic [N-1:0]  i_vote_en;
   logic          o_vld;
   logic          i_rdy;
   logic [RW-1:0] o_p_r;
`ifdef PRIORITY_MASK_LVL_EN
   logic [N*LVL_W-1:0] o_lvl;
   logic [N-1:0]       o_hit;
`endif

   int total;
   int bad;
   logic [RW-1:0] exp_q[$];

   priority_mask_pipe #(.N(N), .P(P)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_flush   (i_flush),
      .i_vld     (i_vld),
      .o_rdy     (o_rdy),
      .i_p_o     (i_p_o),
      .i_vote_en (i_vote_en),
      .o_vld     (o_vld),
      .i_rdy     (i_rdy),
      .o_p_r     (o_p_r)
`ifdef PRIORITY_MASK_LVL_EN
      ,
      .o_lvl     (o_lvl),
      .o_hit     (o_hit)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Highest level whose enabled voters are unanimous (and non-empty).
   function automatic logic [RW-1:0] model(logic [OW-1:0] po,
                                           logic [N-1:0] en);
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = P - 1; j >= 0; j--) begin
            int votes;
            int yes;
            votes = 0;
            yes = 0;
            for (int n = 0; n < N; n++) begin
               if (en[n]) begin
                  votes++;
                  if (po[n*P*N + j*N + i]) yes++;
               end
            end
            if (votes > 0 && yes == votes) begin
               r[j*N + i] = 1'b1;
               break;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [OW-1:0] rand_po();
      logic [OW-1:0] r;
      for (int b = 0; b < OW; b++) r[b] = ($urandom % 8) != 0;
      return r;
   endfunction

   function automatic logic [N-1:0] rand_en();
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom % 2) != 0;
      if ($urandom % 4 == 0) r = '1;
      return r;
   endfunction

   // One clock; updates the in-flight queue from the handshakes seen.
   task automatic tick(output bit fire, output logic [RW-1:0] got,
                       output logic [RW-1:0] exp);
      #1;
      fire = o_vld & i_rdy & ~i_flush;
      got  = o_p_r;
      exp  = '0;
      if (i_flush) begin
         exp_q.delete();
      end else begin
         if (fire) exp = (exp_q.size() > 0) ? exp_q.pop_front() : {RW{1'bx}};
         if (i_vld & o_rdy) exp_q.push_back(model(i_p_o, i_vote_en));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_flush = 1'b0;
      i_vld = 1'b0;
      i_rdy = 1'b0;
      i_p_o = '0;
      i_vote_en = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (o_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_vld got=%b want=0", o_vld);
      end
      total++;
      if (o_p_r !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", o_p_r);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (o_rdy !== 1'b1) begin
         bad++;
         $display("FAIL reset_rdy got=%b want=1", o_rdy);
      end
   endtask

   task automatic test_full_agree();
      bit fire;
      logic [RW-1:0] got, exp, want;
      i_p_o = '0;
      for (int n = 0; n < N; n++) begin
         i_p_o[n*P*N + 0*N + 2] = 1'b1;
         i_p_o[n*P*N + 2*N + 2] = 1'b1;
      end
      i_vote_en = '1;
      want = model(i_p_o, i_vote_en);
      i_vld = 1'b1;
      i_rdy = 1'b1;
      tick(fire, got, exp);
      i_vld = 1'b0;
      total++;
      if (o_vld !== 1'b0) begin
         bad++;
         $display("FAIL lat1_vld got=%b want=0", o_vld);
      end
      tick(fire, got, exp);
      total++;
      if (o_vld !== 1'b1) begin
         bad++;
         $display("FAIL lat2_vld got=%b want=1", o_vld);
      end
      total++;
      if (o_p_r[2*N+2] !== 1'b1 || o_p_r[0*N+2] !== 1'b0 ||
          o_p_r[1*N+2] !== 1'b0) begin
         bad++;
         $display("FAIL agree_bits got=%h want lvl2 only on input 2", o_p_r);
      end
      total++;
      if (o_p_r !== want) begin
         bad++;
         $display("FAIL agree_word got=%h want=%h", o_p_r, want);
      end
      tick(fire, got, exp);
   endtask

   task automatic test_voter_disable();
      bit fire;
      logic [RW-1:0] got, exp;
      logic [RW-1:0] outs[$];
      logic [N-1:0] en1;
      i_p_o = '0;
      for (int n = 0; n < 3; n++) i_p_o[n*P*N + 1*N + 0] = 1'b1;
      en1 = '0;
      en1[2:0] = 3'b111;
      i_rdy = 1'b1;
      i_vld = 1'b1;
      i_vote_en = en1;
      tick(fire, got, exp);
      i_vote_en = '0;
      tick(fire, got, exp);
      i_vld = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick(fire, got, exp);
         if (fire) begin
            outs.push_back(got);
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL vote_model got=%h want=%h", got, exp);
            end
         end
      end
      total++;
      if (outs.size() != 2) begin
         bad++;
         $display("FAIL vote_count got=%0d want=2", outs.size());
      end else begin
         total++;
         if (outs[0][1*N+0] !== 1'b1) begin
            bad++;
            $display("FAIL vote_en_part got=%h want bit %0d set", outs[0], N);
         end
         total++;
         if (outs[1] !== '0) begin
            bad++;
            $display("FAIL vote_en_none got=%h want=0", outs[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit fire;
      logic [RW-1:0] got, exp, held;
      logic [OW-1:0] po[4];
      logic [N-1:0] en[4];
      bit have_held;
      bit acc;
      int idx;
      int nout;
      for (int k = 0; k < 4; k++) begin
         po[k] = rand_po();
         en[k] = rand_en();
      end
      idx = 0;
      nout = 0;
      have_held = 0;
      held = '0;
      i_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         i_vld = 1'b1;
         i_p_o = po[idx];
         i_vote_en = en[idx];
         #1;
         total++;
         if (o_rdy !== (exp_q.size() < 2)) begin
            bad++;
            $display("FAIL bp_rdy got=%b want=%b", o_rdy, exp_q.size() < 2);
         end
         if (o_vld) begin
            if (!have_held) begin
               held = o_p_r;
               have_held = 1;
               total++;
               if (held !== model(po[0], en[0])) begin
                  bad++;
                  $display("FAIL bp_first got=%h want=%h", held,
                           model(po[0], en[0]));
               end
            end else begin
               total++;
               if (o_p_r !== held) begin
                  bad++;
                  $display("FAIL bp_stable got=%h want=%h", o_p_r, held);
               end
            end
         end
         acc = i_vld & o_rdy;
         tick(fire, got, exp);
         if (acc) idx++;
      end
      total++;
      if (idx != 2) begin
         bad++;
         $display("FAIL bp_accepts got=%0d want=2", idx);
      end
      i_rdy = 1'b1;
      for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
         i_vld = idx < 4;
         if (idx < 4) begin
            i_p_o = po[idx];
            i_vote_en = en[idx];
         end
         #1;
         acc = i_vld & o_rdy;
         tick(fire, got, exp);
         if (acc) idx++;
         if (fire) begin
            nout++;
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL bp_order got=%h want=%h", got, exp);
            end
         end
      end
      i_vld = 1'b0;
      total++;
      if (nout != 4 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL bp_drain got=%0d left=%0d want=4 left=0",
                  nout, exp_q.size());
      end
   endtask

   task automatic test_flush();
      bit fire;
      logic [RW-1:0] got, exp;
      logic [RW-1:0] want;
      i_rdy = 1'b0;
      i_vld = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_p_o = rand_po();
         i_vote_en = rand_en();
         tick(fire, got, exp);
      end
      i_p_o = rand_po();
      i_flush = 1'b1;
      tick(fire, got, exp);
      i_flush = 1'b0;
      i_vld = 1'b0;
      total++;
      if (o_vld !== 1'b0) begin
         bad++;
         $display("FAIL flush_vld got=%b want=0", o_vld);
      end
      i_vld = 1'b1;
      i_p_o = rand_po();
      tick(fire, got, exp);
      i_p_o = rand_po();
      i_flush = 1'b1;
      #1;
      total++;
      if (o_rdy !== 1'b1) begin
         bad++;
         $display("FAIL flush_rdy got=%b want=1", o_rdy);
      end
      tick(fire, got, exp);
      i_flush = 1'b0;
      i_vld = 1'b0;
      i_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (o_vld !== 1'b0) begin
            bad++;
            $display("FAIL flush_ghost got=%b want=0 cyc=%0d", o_vld, c);
         end
         tick(fire, got, exp);
      end
      i_p_o = '1;
      i_vote_en = '1;
      want = model(i_p_o, i_vote_en);
      i_vld = 1'b1;
      tick(fire, got, exp);
      i_vld = 1'b0;
      tick(fire, got, exp);
      total++;
      if (o_vld !== 1'b1 || o_p_r !== want) begin
         bad++;
         $display("FAIL flush_after got=%b/%h want=1/%h", o_vld, o_p_r, want);
      end
      tick(fire, got, exp);
   endtask

   task automatic test_reset_mid();
      bit fire;
      logic [RW-1:0] got, exp;
      i_rdy = 1'b0;
      i_vld = 1'b1;
      i_p_o = '1;
      i_vote_en = '1;
      repeat (3) tick(fire, got, exp);
      i_vld = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      total++;
      if (o_vld !== 1'b0 || o_p_r !== '0) begin
         bad++;
         $display("FAIL rst_mid got=%b/%h want=0/0", o_vld, o_p_r);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (o_rdy !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_rdy got=%b want=1", o_rdy);
      end
      i_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (o_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ghost got=%b want=0", o_vld);
         end
         tick(fire, got, exp);
      end
   endtask

   task automatic test_random();
      bit fire;
      logic [RW-1:0] got, exp;
      for (int c = 0; c < 300; c++) begin
         i_flush = ($urandom % 20) == 0;
         i_rdy = i_flush ? 1'b0 : (($urandom % 4) != 0);
         i_vld = ($urandom % 3) != 0;
         i_p_o = rand_po();
         i_vote_en = rand_en();
         #1;
         total++;
         if (o_rdy !== ((exp_q.size() < 2) || i_rdy)) begin
            bad++;
            $display("FAIL rnd_rdy got=%b want=%b cyc=%0d", o_rdy,
                     (exp_q.size() < 2) || i_rdy, c);
         end
         tick(fire, got, exp);
         if (fire) begin
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL rnd_data got=%h want=%h cyc=%0d", got, exp, c);
            end
         end
      end
      i_flush = 1'b0;
      i_vld = 1'b0;
      i_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick(fire, got, exp);
         if (fire) begin
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL rnd_drain got=%h want=%h", got, exp);
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rnd_lost got=%0d want=0", exp_q.size());
      end
   endtask

`ifdef PRIORITY_MASK_LVL_EN
   task automatic test_lvl();
      bit fire;
      logic [RW-1:0] got, exp;
      i_p_o = '0;
      for (int n = 0; n < N; n++) begin
         i_p_o[n*P*N + 6*N + 5] = 1'b1;
         i_p_o[n*P*N + 2*N + 5] = 1'b1;
      end
      i_vote_en = '1;
      i_rdy = 1'b1;
      i_vld = 1'b1;
      tick(fire, got, exp);
      i_vld = 1'b0;
      tick(fire, got, exp);
      total++;
      if (o_lvl[5*LVL_W +: LVL_W] !== 3'd6 || o_hit[5] !== 1'b1) begin
         bad++;
         $display("FAIL lvl_win got=%0d/%b want=6/1",
                  o_lvl[5*LVL_W +: LVL_W], o_hit[5]);
      end
      total++;
      if (o_lvl[0 +: LVL_W] !== 3'd0 || o_hit[0] !== 1'b0) begin
         bad++;
         $display("FAIL lvl_none got=%0d/%b want=0/0",
                  o_lvl[0 +: LVL_W], o_hit[0]);
      end
      tick(fire, got, exp);
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_full_agree();
      test_voter_disable();
      test_backpressure();
      test_flush();
      test_reset_mid();
`ifdef PRIORITY_MASK_LVL_EN
      test_lvl();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
